// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared Wishbone slave constants and FSM state type
package wb_pkg;

  // Slave bus-cycle phases: waiting for a cycle, counting wait states, terminating
  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } wb_state_e;

  // Data returned alongside an error termination
  localparam logic [15:0] ERR_PATTERN = 16'hE550;

  // Default register map, shared with the master-side software model
  localparam logic [31:0] DEF_LED_ADDR = 32'h0000_1000;
  localparam logic [31:0] DEF_TXN_ADDR = DEF_LED_ADDR + 32'd1;

endpackage

// File: rtl/wb_byte_ram.sv
// rtl/wb_byte_ram.sv - single-port synchronous RAM with byte-lane write enables
module wb_byte_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  localparam int SEL_W = DATA_W / 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rd_en,
  input  logic [SEL_W-1:0]  i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Per-lane write; read register only updates when a read is requested so it holds otherwise
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < SEL_W; i++) begin
      if (i_we[i]) begin
        r_mem[i_addr][i*8 +: 8] <= i_wdata[i*8 +: 8];
      end
    end
    if (i_rd_en) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/wb_ram_led_slave.sv
// rtl/wb_ram_led_slave.sv - Wishbone classic slave: byte RAM, LED register, transaction counter
module wb_ram_led_slave
  import wb_pkg::*;
#(
  parameter int WB_BUS_WIDTH  = 16,
  parameter int WB_ADDR_WIDTH = 32,
  parameter int MEM_DEPTH     = 256,
  parameter logic [WB_ADDR_WIDTH-1:0] LED_ADDR = WB_ADDR_WIDTH'(DEF_LED_ADDR),
  parameter logic [WB_ADDR_WIDTH-1:0] TXN_ADDR = LED_ADDR + WB_ADDR_WIDTH'(1),
  parameter int LED_WIDTH     = 16,
  parameter int WAIT_STATES   = 1,
  localparam int WB_SEL       = WB_BUS_WIDTH / 8,
  localparam int MEM_AW       = $clog2(MEM_DEPTH)
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_reset_i,
  input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [WB_BUS_WIDTH-1:0]  wb_data_i,
  input  logic [WB_SEL-1:0]        wb_sel_i,
  input  logic                     wb_we_i,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  input  logic                     wb_lock_i,
  output logic [WB_BUS_WIDTH-1:0]  wb_data_o,
  output logic                     wb_ack_o,
  output logic                     wb_err_o,
  output logic                     wb_stall_o,
  output logic                     wb_rty_o,
  output logic [LED_WIDTH-1:0]     led_o
);

  wb_state_e                r_state;
  logic [3:0]               r_cnt;
  logic [WB_ADDR_WIDTH-1:0] r_addr;
  logic [WB_BUS_WIDTH-1:0]  r_wdata;
  logic [WB_SEL-1:0]        r_sel;
  logic                     r_we;
  logic                     r_ack;
  logic                     r_err;
  logic                     r_stall;
  logic                     r_rd_ram;
  logic [WB_BUS_WIDTH-1:0]  r_rdata;
  logic [LED_WIDTH-1:0]     r_led;
  logic [WB_BUS_WIDTH-1:0]  r_txn;

  logic                     w_ram_hit;
  logic                     w_led_hit;
  logic                     w_txn_hit;
  logic                     w_err;
  logic                     w_commit;
  logic [WB_SEL-1:0]        w_ram_we;
  logic                     w_ram_re;
  logic [WB_BUS_WIDTH-1:0]  w_ram_rdata;
  logic [WB_BUS_WIDTH-1:0]  w_mask;
  logic [WB_BUS_WIDTH-1:0]  w_led_bus;
  logic [WB_BUS_WIDTH-1:0]  w_led_next_bus;
  logic [WB_BUS_WIDTH-1:0]  w_rd_reg;
  logic                     w_unused;

  // Lock has no meaning for a single-master slave
  assign w_unused = wb_lock_i;

  // Decode is done on the latched address so the master may change the bus while stalled
  assign w_ram_hit = (r_addr < WB_ADDR_WIDTH'(MEM_DEPTH));
  assign w_led_hit = (r_addr == LED_ADDR);
  assign w_txn_hit = (r_addr == TXN_ADDR);
  assign w_err     = !(w_ram_hit || w_led_hit || w_txn_hit) || (w_txn_hit && r_we);

  // Last wait cycle with the master still present: the point where side effects happen
  assign w_commit  = (r_state == S_WAIT) && wb_cyc_i && (r_cnt == 4'd0);
  assign w_ram_we  = {WB_SEL{w_commit && r_we && w_ram_hit}} & r_sel;
  assign w_ram_re  = w_commit && !r_we && w_ram_hit;

  // Expand byte selects into a bit mask and merge write data into the LED register
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < WB_SEL; i++) begin
      w_mask[i*8 +: 8] = {8{r_sel[i]}};
    end
  end

  assign w_led_bus      = WB_BUS_WIDTH'(r_led);
  assign w_led_next_bus = (w_led_bus & ~w_mask) | (r_wdata & w_mask);

  // Read data for everything that is not RAM, including the error pattern
  always_comb begin
    w_rd_reg = '0;
    if (w_err) begin
      w_rd_reg = WB_BUS_WIDTH'(ERR_PATTERN);
    end else if (w_led_hit) begin
      w_rd_reg = w_led_bus;
    end else if (w_txn_hit) begin
      w_rd_reg = r_txn;
    end
  end

  wb_byte_ram #(
    .DATA_W (WB_BUS_WIDTH),
    .DEPTH  (MEM_DEPTH)
  ) u_ram (
    .i_clk   (wb_clk_i),
    .i_rd_en (w_ram_re),
    .i_we    (w_ram_we),
    .i_addr  (r_addr[MEM_AW-1:0]),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_rdata)
  );

  // Bus-cycle FSM with registered terminations, LED register and transaction counter
  always_ff @(posedge wb_clk_i or negedge wb_reset_i) begin
    if (!wb_reset_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_sel    <= '0;
      r_we     <= 1'b0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_stall  <= 1'b0;
      r_rd_ram <= 1'b0;
      r_rdata  <= '0;
      r_led    <= '0;
      r_txn    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            r_addr  <= wb_addr_i;
            r_wdata <= wb_data_i;
            r_sel   <= wb_sel_i;
            r_we    <= wb_we_i;
            r_cnt   <= 4'(WAIT_STATES - 1);
            r_stall <= 1'b1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!wb_cyc_i) begin
            r_stall <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_cnt == 4'd0) begin
            r_ack   <= !w_err;
            r_err   <= w_err;
            r_state <= S_ACK;
            if (w_err || !r_we) begin
              r_rd_ram <= !w_err && w_ram_hit;
              r_rdata  <= w_rd_reg;
            end
            if (!w_err && r_we && w_led_hit) begin
              r_led <= w_led_next_bus[LED_WIDTH-1:0];
            end
            if (!w_err) begin
              r_txn <= r_txn + WB_BUS_WIDTH'(1);
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_ACK: begin
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
          r_stall <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_stall <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign wb_data_o  = r_rd_ram ? w_ram_rdata : r_rdata;
  assign wb_ack_o   = r_ack;
  assign wb_err_o   = r_err;
  assign wb_stall_o = r_stall;
  assign wb_rty_o   = 1'b0;
  assign led_o      = r_led;

endmodule

// File: tb/tb_wb_ram_led_slave.sv
// tb/tb_wb_ram_led_slave.sv - self-checking bench for wb_ram_led_slave
module tb_wb_ram_led_slave;

  localparam int          A_WS  = 1;
  localparam int          B_WS  = 4;
  localparam logic [31:0] LED_A = 32'h0000_1000;
  localparam logic [31:0] TXN_A = 32'h0000_1001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Instance A: default 16-bit configuration
  logic        a_rst_n, a_we, a_cyc, a_stb, a_lock;
  logic [31:0] a_addr;
  logic [15:0] a_wdat, a_rdata, a_led;
  logic [1:0]  a_sel;
  logic        a_ack, a_err, a_stall, a_rty;

  // Instance B: 8-bit bus, four wait states
  logic        b_rst_n, b_we, b_cyc, b_stb, b_lock;
  logic [31:0] b_addr;
  logic [7:0]  b_wdat, b_rdata, b_led;
  logic [0:0]  b_sel;
  logic        b_ack, b_err, b_stall, b_rty;

  wb_ram_led_slave #(.WAIT_STATES(A_WS)) dut_a (
    .wb_clk_i(clk), .wb_reset_i(a_rst_n), .wb_addr_i(a_addr), .wb_data_i(a_wdat),
    .wb_sel_i(a_sel), .wb_we_i(a_we), .wb_cyc_i(a_cyc), .wb_stb_i(a_stb),
    .wb_lock_i(a_lock), .wb_data_o(a_rdata), .wb_ack_o(a_ack), .wb_err_o(a_err),
    .wb_stall_o(a_stall), .wb_rty_o(a_rty), .led_o(a_led)
  );

  wb_ram_led_slave #(.WB_BUS_WIDTH(8), .LED_WIDTH(8), .WAIT_STATES(B_WS)) dut_b (
    .wb_clk_i(clk), .wb_reset_i(b_rst_n), .wb_addr_i(b_addr), .wb_data_i(b_wdat),
    .wb_sel_i(b_sel), .wb_we_i(b_we), .wb_cyc_i(b_cyc), .wb_stb_i(b_stb),
    .wb_lock_i(b_lock), .wb_data_o(b_rdata), .wb_ack_o(b_ack), .wb_err_o(b_err),
    .wb_stall_o(b_stall), .wb_rty_o(b_rty), .led_o(b_led)
  );

  // Behavioural model of instance A
  logic [15:0] m_ram [256];
  logic [15:0] m_led, m_txn;
  logic        exp_ack, exp_err, exp_stall;
  logic [15:0] exp_data;
  logic        mon_en = 1'b0;

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endfunction

  // Every cycle, instance A outputs must match the model
  always @(negedge clk) begin
    if (mon_en) begin
      check("a_ack",   a_ack,   exp_ack);
      check("a_err",   a_err,   exp_err);
      check("a_stall", a_stall, exp_stall);
      check("a_data",  a_rdata, exp_data);
      check("a_led",   a_led,   m_led);
      check("a_rty",   a_rty,   1'b0);
    end
  end

  // One transaction on A; the model predicts its outcome and schedules expected outputs by cycle
  task automatic txn_a(input logic we, input logic [31:0] addr, input logic [15:0] data,
                       input logic [1:0] sel, output logic [15:0] rd, output logic ak, output logic er);
    logic        err;
    logic [15:0] r;
    a_we = we; a_addr = addr; a_wdat = data; a_sel = sel; a_cyc = 1'b1; a_stb = 1'b1;
    @(posedge clk); #1;
    exp_stall = 1'b1;
    a_we = ~we; a_addr = ~addr; a_wdat = ~data; a_sel = ~sel;
    for (int i = 1; i < A_WS; i++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    r   = 16'h0000;
    err = 1'b1;
    if (addr < 32'd256) begin
      err = 1'b0;
      if (we) begin
        if (sel[0]) m_ram[addr[7:0]][7:0]  = data[7:0];
        if (sel[1]) m_ram[addr[7:0]][15:8] = data[15:8];
      end else r = m_ram[addr[7:0]];
    end else if (addr == LED_A) begin
      err = 1'b0;
      if (we) begin
        if (sel[0]) m_led[7:0]  = data[7:0];
        if (sel[1]) m_led[15:8] = data[15:8];
      end else r = m_led;
    end else if (addr == TXN_A) begin
      err = we;
      r   = m_txn;
    end
    if (err) r = 16'hE550;
    exp_ack = !err;
    exp_err = err;
    if (err || !we) exp_data = r;
    if (!err) m_txn = m_txn + 16'd1;
    rd = a_rdata; ak = a_ack; er = a_err;
    @(posedge clk); #1;
    a_cyc = 1'b0; a_stb = 1'b0;
    exp_ack = 1'b0; exp_err = 1'b0; exp_stall = 1'b0;
  endtask

  // One transaction on B, waiting a bounded number of cycles for termination
  task automatic txn_b(input logic we, input logic [31:0] addr, input logic [7:0] data,
                       output logic [7:0] rd, output logic ak, output logic er, output int lat);
    b_we = we; b_addr = addr; b_wdat = data; b_sel = 1'b1; b_cyc = 1'b1; b_stb = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!(b_ack || b_err) && lat < 32) begin @(posedge clk); #1; lat++; end
    rd = b_rdata; ak = b_ack; er = b_err;
    @(posedge clk); #1;
    b_cyc = 1'b0; b_stb = 1'b0;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    logic [7:0]  rdb;
    logic        ak, er;
    int          lat, n_ack, n_seen;

    a_rst_n = 1'b0; a_we = 1'b0; a_cyc = 1'b0; a_stb = 1'b0; a_lock = 1'b0;
    a_addr = '0; a_wdat = '0; a_sel = '0;
    b_rst_n = 1'b0; b_we = 1'b0; b_cyc = 1'b0; b_stb = 1'b0; b_lock = 1'b0;
    b_addr = '0; b_wdat = '0; b_sel = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack",   a_ack,   1'b0);
    check("rst_err",   a_err,   1'b0);
    check("rst_stall", a_stall, 1'b0);
    check("rst_data",  a_rdata, 16'h0000);
    check("rst_led",   a_led,   16'h0000);
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    m_led = 16'h0; m_txn = 16'h0; exp_data = 16'h0;
    exp_ack = 1'b0; exp_err = 1'b0; exp_stall = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    txn_a(1'b1, 32'h10, 16'hA5C3, 2'b11, rd, ak, er); check("w10_ack", ak, 1'b1);
    txn_a(1'b0, 32'h10, 16'h0, 2'b11, rd, ak, er);    check("r10", rd, 16'hA5C3);
    txn_a(1'b0, TXN_A, 16'h0, 2'b11, rd, ak, er);     check("txn_2", rd, 16'd2);
    txn_a(1'b1, 32'h10, 16'h1234, 2'b11, rd, ak, er);
    txn_a(1'b1, 32'h10, 16'hFFFF, 2'b01, rd, ak, er);
    txn_a(1'b0, 32'h10, 16'h0, 2'b11, rd, ak, er);    check("r10_lane", rd, 16'h12FF);
    txn_a(1'b1, 32'h10, 16'h0000, 2'b00, rd, ak, er); check("sel0_ack", ak, 1'b1);
    txn_a(1'b0, 32'h10, 16'h0, 2'b11, rd, ak, er);    check("r10_sel0", rd, 16'h12FF);
    txn_a(1'b1, LED_A, 16'h00F0, 2'b11, rd, ak, er);  check("led_00f0", a_led, 16'h00F0);
    txn_a(1'b1, LED_A, 16'hAB55, 2'b10, rd, ak, er);
    txn_a(1'b0, LED_A, 16'h0, 2'b11, rd, ak, er);     check("led_rd", rd, 16'hABF0);
    txn_a(1'b1, 32'hFF, 16'h7E81, 2'b11, rd, ak, er);
    txn_a(1'b0, 32'hFF, 16'h0, 2'b11, rd, ak, er);    check("r_top", rd, 16'h7E81);
    txn_a(1'b0, 32'h100, 16'h0, 2'b11, rd, ak, er);
    check("r100_err", er, 1'b1); check("r100_noack", ak, 1'b0); check("r100_data", rd, 16'hE550);
    txn_a(1'b0, 32'h2000, 16'h0, 2'b11, rd, ak, er);
    check("r2000_err", er, 1'b1); check("r2000_data", rd, 16'hE550);
    txn_a(1'b1, TXN_A, 16'h0000, 2'b11, rd, ak, er);  check("wtxn_err", er, 1'b1);
    txn_a(1'b0, TXN_A, 16'h0, 2'b11, rd, ak, er);     check("txn_13", rd, 16'd13);

    // Reset in the middle of an LED write
    a_we = 1'b1; a_addr = LED_A; a_wdat = 16'hBEEF; a_sel = 2'b11; a_cyc = 1'b1; a_stb = 1'b1;
    @(posedge clk); #1;
    exp_stall = 1'b1;
    #2;
    a_rst_n = 1'b0; a_cyc = 1'b0; a_stb = 1'b0;
    exp_stall = 1'b0; exp_data = 16'h0; m_led = 16'h0; m_txn = 16'h0;
    #1;
    check("mid_rst_led",   a_led,   16'h0000);
    check("mid_rst_stall", a_stall, 1'b0);
    @(posedge clk); #1;
    a_rst_n = 1'b1;
    @(posedge clk); #1;
    txn_a(1'b0, LED_A, 16'h0, 2'b11, rd, ak, er);     check("post_rst_led", rd, 16'h0000);
    txn_a(1'b0, TXN_A, 16'h0, 2'b11, rd, ak, er);     check("post_rst_txn", rd, 16'd1);
    txn_a(1'b0, 32'h10, 16'h0, 2'b11, rd, ak, er);    check("ram_kept", rd, 16'h12FF);

    // Instance B: latency, abort, counter wrap, truncated error pattern
    txn_b(1'b1, 32'h20, 8'h5A, rdb, ak, er, lat);
    check("b_w_ack", ak, 1'b1); check("b_latency", lat, B_WS);
    b_we = 1'b1; b_addr = 32'h20; b_wdat = 8'hC3; b_sel = 1'b1; b_cyc = 1'b1; b_stb = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    b_cyc = 1'b0; b_stb = 1'b0;
    n_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (b_ack || b_err) n_seen++;
    end
    check("b_abort_noterm", n_seen, 0);
    check("b_abort_stall", b_stall, 1'b0);
    txn_b(1'b0, 32'h20, 8'h0, rdb, ak, er, lat);      check("b_ram_kept", rdb, 8'h5A);
    txn_b(1'b0, TXN_A, 8'h0, rdb, ak, er, lat);       check("b_txn_2", rdb, 8'd2);
    n_ack = 0;
    for (int i = 0; i < 252; i++) begin
      txn_b(1'b0, 32'h20, 8'h0, rdb, ak, er, lat);
      if (ak) n_ack++;
    end
    check("b_fill_acks", n_ack, 252);
    txn_b(1'b0, TXN_A, 8'h0, rdb, ak, er, lat);       check("b_txn_ff", rdb, 8'hFF);
    txn_b(1'b0, TXN_A, 8'h0, rdb, ak, er, lat);       check("b_txn_wrap", rdb, 8'h00);
    txn_b(1'b0, 32'h2000, 8'h0, rdb, ak, er, lat);
    check("b_err", er, 1'b1); check("b_err_data", rdb, 8'h50);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
